// File: rtl/spi_flash_line_reader.sv
// spi_flash_line_reader
//   Read-only SPI flash (Mode 0) bridge for a 6809 bus. A read that misses the
//   one-line buffer fetches a whole LINE_BYTES line from flash while holding
//   MRDY low. Reads that hit the buffered line are answered at the sampling
//   edge with no wait states.
// Ports
//   clk            system clock
//   reset          asynchronous, active-low reset
//   i_CE           flash window select from the address decoder
//   i_RW           1 = read cycle (writes are ignored)
//   i_ADDRESS_BUS  CPU address, low ADDR_BITS bits forwarded to flash
//   i_FLUSH        one-cycle pulse that invalidates the line buffer
//   i_SPI_MISO     flash serial data out
//   o_SPI_CLK      SCK, idles low
//   o_SPI_MOSI     flash serial data in, 0 whenever CS is high
//   o_SPI_CS       flash chip select, active low
//   o_DATA         read data to the CPU
//   o_MemoryReady  MRDY to the 6809, low stretches the CPU cycle
module spi_flash_line_reader #(
  parameter int unsigned ADDR_BITS  = 12,
  parameter logic [23:0] FLASH_BASE = 24'h0,
  parameter int unsigned LINE_BYTES = 8,
  parameter int unsigned CLK_DIV    = 1,
  parameter bit          FAST_READ  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_CE,
  input  logic        i_RW,
  input  logic [15:0] i_ADDRESS_BUS,
  input  logic        i_FLUSH,
  input  logic        i_SPI_MISO,
  output logic        o_SPI_CLK,
  output logic        o_SPI_MOSI,
  output logic        o_SPI_CS,
  output logic [7:0]  o_DATA,
  output logic        o_MemoryReady
);
  localparam int unsigned OFF_W    = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int unsigned HDR_BITS = FAST_READ ? 40 : 32;
  localparam int unsigned NBITS    = HDR_BITS + 8 * LINE_BYTES;
  localparam int unsigned CNT_W    = $clog2(NBITS + 1);
  localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [7:0]  CMD_BYTE = FAST_READ ? 8'h0B : 8'h03;
  localparam logic [ADDR_BITS-1:0] OFF_MASK = ADDR_BITS'(LINE_BYTES - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA, ST_DONE
  } state_t;

  state_t               state;
  logic [ADDR_BITS-1:0] line_tag;   // line-aligned address of the buffered line
  logic [ADDR_BITS-1:0] req_line;
  logic [OFF_W-1:0]     req_off;
  logic                 valid;
  logic                 flush_pend; // flush seen while a fetch was in flight
  logic [DIV_W-1:0]     div_cnt;
  logic [CNT_W-1:0]     bit_cnt;    // SPI bits completed in this transfer
  logic [30:0]          tx_sh;      // bits still to send after the one on MOSI
  logic [6:0]           rx_sh;
  logic [7:0]           line_mem [LINE_BYTES];

  logic [ADDR_BITS-1:0] cpu_addr;
  logic [ADDR_BITS-1:0] cpu_line;
  logic [OFF_W-1:0]     cpu_off;
  logic                 unused_addr;
  logic                 sck_tick;
  logic [CNT_W-1:0]     bit_nxt;
  logic [CNT_W-1:0]     data_idx;
  logic                 wr_en;
  logic [OFF_W-1:0]     wr_addr;
  logic [7:0]           wr_data;

  assign cpu_addr    = i_ADDRESS_BUS[ADDR_BITS-1:0];
  assign cpu_line    = cpu_addr & ~OFF_MASK;
  assign cpu_off     = OFF_W'(cpu_addr & OFF_MASK);
  assign unused_addr = ^(i_ADDRESS_BUS >> ADDR_BITS);

  assign sck_tick = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign bit_nxt  = bit_cnt + 1'b1;
  assign data_idx = bit_cnt - CNT_W'(HDR_BITS);

  // A byte is complete on the rising SCK edge that samples its eighth bit.
  assign wr_en   = (state == ST_DATA) && sck_tick && !o_SPI_CLK && (data_idx[2:0] == 3'b111);
  assign wr_addr = OFF_W'(data_idx >> 3);
  assign wr_data = {rx_sh, i_SPI_MISO};

  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      line_tag      <= '0;
      req_line      <= '0;
      req_off       <= '0;
      valid         <= 1'b0;
      flush_pend    <= 1'b0;
      div_cnt       <= '0;
      bit_cnt       <= '0;
      tx_sh         <= '0;
      rx_sh         <= '0;
      o_SPI_CLK     <= 1'b0;
      o_SPI_MOSI    <= 1'b0;
      o_SPI_CS      <= 1'b1;
      o_DATA        <= 8'h00;
      o_MemoryReady <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_FLUSH) begin
            valid <= 1'b0;
          end
          if (i_CE && i_RW) begin
            if (valid && !i_FLUSH && (cpu_line == line_tag)) begin
              o_DATA <= line_mem[cpu_off];
            end else begin
              req_line      <= cpu_line;
              req_off       <= cpu_off;
              o_SPI_CS      <= 1'b0;
              o_MemoryReady <= 1'b0;
              o_SPI_MOSI    <= CMD_BYTE[7];
              tx_sh         <= {CMD_BYTE[6:0], FLASH_BASE + 24'(cpu_line)};
              div_cnt       <= '0;
              bit_cnt       <= '0;
              flush_pend    <= 1'b0;
              state         <= ST_CMD;
            end
          end
        end
        ST_DONE: begin
          o_SPI_CS      <= 1'b1;
          o_SPI_MOSI    <= 1'b0;
          o_DATA        <= line_mem[req_off];
          valid         <= !(flush_pend || i_FLUSH);
          line_tag      <= req_line;
          o_MemoryReady <= 1'b1;
          state         <= ST_IDLE;
        end
        default: begin
          if (i_FLUSH) begin
            flush_pend <= 1'b1;
          end
          if (sck_tick) begin
            div_cnt   <= '0;
            o_SPI_CLK <= !o_SPI_CLK;
            if (!o_SPI_CLK) begin
              rx_sh <= {rx_sh[5:0], i_SPI_MISO};
            end else begin
              // Falling edge: bit finished, present the next one while SCK is low.
              // Zeros shifted in keep MOSI at 0 through DUMMY and DATA.
              bit_cnt    <= bit_nxt;
              o_SPI_MOSI <= tx_sh[30];
              tx_sh      <= {tx_sh[29:0], 1'b0};
              if (bit_nxt == CNT_W'(NBITS)) begin
                state <= ST_DONE;
              end else if (bit_nxt == CNT_W'(8)) begin
                state <= ST_ADDR;
              end else if (bit_nxt == CNT_W'(32)) begin
                state <= FAST_READ ? ST_DUMMY : ST_DATA;
              end else if (bit_nxt == CNT_W'(40)) begin
                state <= ST_DATA;
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_line_reader.sv
// Bench for spi_flash_line_reader: three instances (plain read, FAST_READ,
// CLK_DIV=3 with a non-zero flash base), each with its own behavioural flash.
module tb_spi_flash_line_reader;
  localparam logic [2:0]  FRV   = 3'b010;
  localparam logic [11:0] CDV   = {4'd3, 4'd1, 4'd1};
  localparam logic [71:0] BASEV = {24'h010000, 24'h000000, 24'h000000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n [3];
  logic        ce    [3];
  logic        rw    [3];
  logic        flush [3];
  logic [15:0] addr  [3];
  wire         miso  [3];
  wire         sck   [3];
  wire         mosi  [3];
  wire         cs    [3];
  wire         rdy   [3];
  wire  [7:0]  dout  [3];
  wire  [7:0]  obs_cmd  [3];
  wire  [23:0] obs_addr [3];
  wire  [31:0] rises    [3];
  wire  [31:0] mosi_bad [3];
  wire  [31:0] per_bad  [3];

  int errors = 0;
  int checks = 0;
  logic [7:0] sb [$];
  logic [7:0] last_exp [3];

  function automatic logic [7:0] mem(input logic [23:0] a);
    logic [7:0] t;
    t = a[7:0] * 8'd7;
    return t ^ a[15:8] ^ {a[19:16], 4'h3} ^ 8'hA5;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_slot
    localparam int CD  = int'(CDV[gi*4 +: 4]);
    localparam bit FR  = FRV[gi];
    localparam int HDR = FR ? 40 : 32;

    spi_flash_line_reader #(
      .ADDR_BITS (12),
      .FLASH_BASE(BASEV[gi*24 +: 24]),
      .LINE_BYTES(8),
      .CLK_DIV   (CD),
      .FAST_READ (FR)
    ) u_dut (
      .clk          (clk),
      .reset        (rst_n[gi]),
      .i_CE         (ce[gi]),
      .i_RW         (rw[gi]),
      .i_ADDRESS_BUS(addr[gi]),
      .i_FLUSH      (flush[gi]),
      .i_SPI_MISO   (miso[gi]),
      .o_SPI_CLK    (sck[gi]),
      .o_SPI_MOSI   (mosi[gi]),
      .o_SPI_CS     (cs[gi]),
      .o_DATA       (dout[gi]),
      .o_MemoryReady(rdy[gi])
    );

    // Behavioural flash: captures cmd/address, shifts data out after SCK falls.
    logic [31:0] sh     = '0;
    int          cnt    = 0;
    logic [7:0]  cmd_r  = '0;
    logic [23:0] addr_r = '0;
    logic        miso_r = 1'b0;
    int          rise_n = 0;
    int          mbad   = 0;
    int          pbad   = 0;
    int          run    = 0;
    logic        psck   = 1'b0;
    logic        pmosi  = 1'b0;

    always @(negedge cs[gi]) cnt = 0;

    always @(posedge sck[gi]) begin
      rise_n++;
      if (cs[gi] === 1'b0) begin
        sh = {sh[30:0], mosi[gi]};
        cnt++;
        if (cnt == 32) begin
          cmd_r  = sh[31:24];
          addr_r = sh[23:0];
        end
      end
    end

    always @(negedge sck[gi]) begin
      if (cs[gi] === 1'b0 && cnt >= HDR) begin
        int k;
        logic [7:0] d;
        k = cnt - HDR;
        d = mem(addr_r + 24'(k / 8));
        miso_r = d[7 - (k % 8)];
      end
    end

    // SCK phase lengths and MOSI stability while SCK is high.
    always @(negedge clk) begin
      if (cs[gi] !== 1'b0) begin
        run  = 0;
        psck = 1'b0;
        if (rst_n[gi] === 1'b1 && mosi[gi] !== 1'b0) mbad++;
      end else begin
        if (sck[gi] === psck) begin
          run++;
        end else begin
          if (run != CD) pbad++;
          run = 1;
        end
        if (sck[gi] === 1'b1 && mosi[gi] !== pmosi) mbad++;
        psck  = sck[gi];
        pmosi = mosi[gi];
      end
    end

    assign miso[gi]     = miso_r;
    assign obs_cmd[gi]  = cmd_r;
    assign obs_addr[gi] = addr_r;
    assign rises[gi]    = rise_n;
    assign mosi_bad[gi] = mbad;
    assign per_bad[gi]  = pbad;
  end

  // flush_at: -1 none, 0 together with the request, n>0 n cycles into the fetch
  task automatic do_read(input int s, input logic [15:0] a, input bit miss, input int flush_at);
    logic [23:0] la;
    logic [7:0]  exp_d;
    int lat, r0, cd, nb;
    cd = int'(CDV[s*4 +: 4]);
    nb = 96 + 8 * int'(FRV[s]);
    la = BASEV[s*24 +: 24] + {12'h000, a[11:3], 3'b000};
    @(negedge clk);
    ce[s]    = 1'b1;
    rw[s]    = 1'b1;
    addr[s]  = a;
    flush[s] = (flush_at == 0);
    sb.push_back(mem(la + {21'h0, a[2:0]}));
    r0 = rises[s];
    @(posedge clk); #1;
    flush[s] = 1'b0;
    lat = 0;
    if (miss) begin
      check("miss_rdy_low", rdy[s], 0);
      check("miss_cs_low", cs[s], 0);
      lat = 1;
      for (int k = 0; k < 5000 && rdy[s] !== 1'b1; k++) begin
        flush[s] = (lat == flush_at);
        @(posedge clk); #1;
        flush[s] = 1'b0;
        if (rdy[s] !== 1'b1) lat++;
      end
      check("miss_latency", lat, 2 * cd * nb + 1);
      check("cs_released", cs[s], 1);
      check("spi_cmd", obs_cmd[s], FRV[s] ? 8'h0B : 8'h03);
      check("spi_addr", obs_addr[s], la);
    end else begin
      check("hit_rdy", rdy[s], 1);
      check("hit_no_sck", rises[s] - r0, 0);
    end
    ce[s] = 1'b0;
    exp_d = sb.pop_front();
    check("rdata", dout[s], exp_d);
    last_exp[s] = exp_d;
    $display("read slot=%0d addr=%h %s lat=%0d data=%h exp=%h", s, a, miss ? "miss" : "hit", lat, dout[s], exp_d);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int bad, r0;
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; ce[i] = 1'b0; rw[i] = 1'b1; flush[i] = 1'b0; addr[i] = 16'h0; last_exp[i] = 8'h00;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_cs", cs[i], 1);
      check("rst_sck", sck[i], 0);
      check("rst_mosi", mosi[i], 0);
      check("rst_rdy", rdy[i], 1);
      check("rst_dout", dout[i], 0);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;

    // plain READ, CLK_DIV=1
    do_read(0, 16'h0123, 1'b1, -1);
    do_read(0, 16'h0127, 1'b0, -1);
    do_read(0, 16'h0128, 1'b1, -1);
    do_read(0, 16'h0120, 1'b1, -1);

    // write cycle: no SPI activity, ready high, data held
    @(negedge clk);
    ce[0] = 1'b1; rw[0] = 1'b0; addr[0] = 16'h0500;
    bad = 0;
    r0 = rises[0];
    repeat (6) begin
      @(posedge clk); #1;
      if (cs[0] !== 1'b1 || rdy[0] !== 1'b1) bad++;
    end
    ce[0] = 1'b0; rw[0] = 1'b1;
    check("wr_no_cs", bad, 0);
    check("wr_no_sck", rises[0] - r0, 0);
    check("wr_dout", dout[0], last_exp[0]);
    $display("write slot=0 addr=0500 dout=%h", dout[0]);

    // flush in idle then refetch
    @(negedge clk); flush[0] = 1'b1;
    @(negedge clk); flush[0] = 1'b0;
    do_read(0, 16'h0124, 1'b1, -1);
    do_read(0, 16'h0127, 1'b0, -1);

    // flush mid-fetch: data delivered, line not kept
    do_read(0, 16'h0300, 1'b1, 50);
    do_read(0, 16'h0301, 1'b1, -1);
    do_read(0, 16'h0302, 1'b0, -1);

    // reset in the middle of the address phase
    @(negedge clk);
    ce[0] = 1'b1; rw[0] = 1'b1; addr[0] = 16'h0345;
    repeat (30) @(posedge clk);
    #2;
    rst_n[0] = 1'b0;
    #1;
    check("abort_cs", cs[0], 1);
    check("abort_sck", sck[0], 0);
    check("abort_rdy", rdy[0], 1);
    ce[0] = 1'b0;
    $display("reset slot=0 mid-fetch cs=%b sck=%b rdy=%b", cs[0], sck[0], rdy[0]);
    @(negedge clk); rst_n[0] = 1'b1;
    do_read(0, 16'h0302, 1'b1, -1);
    do_read(0, 16'h0345, 1'b1, -1);
    // flush coincident with a request in the same line: treated as miss
    do_read(0, 16'h0346, 1'b1, 0);
    do_read(0, 16'h0347, 1'b0, -1);

    // FAST_READ
    do_read(1, 16'h0123, 1'b1, -1);
    do_read(1, 16'h0125, 1'b0, -1);
    do_read(1, 16'h0FF8, 1'b1, -1);

    // CLK_DIV=3, flash base 0x010000
    do_read(2, 16'h0123, 1'b1, -1);
    do_read(2, 16'h0127, 1'b0, -1);
    do_read(2, 16'h0FFF, 1'b1, -1);

    for (int i = 0; i < 3; i++) begin
      check("mosi_stable", mosi_bad[i], 0);
      check("sck_period", per_bad[i], 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
